mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Sequencer and arbiter that shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (lw/sw). It grants one access at a time and drives the memory port for a fixed access latency. It returns read data to the winning requester and raises a pipeline stall while any request is outstanding. Data accesses win over fetches, with a bounded-starvation guarantee for fetch.

Parameters:
AW, 32, address width
DW, 32, data width
LAT, 2, memory access cycles per transfer (>=1); port held stable for LAT cycles
STARVE_MAX, 4, max consecutive data grants while IfReq pending before fetch is forced

Ports:
Clk  in  1  clock, rising edge
Clrn  in  1  reset, asynchronous, active-low
IfReq  in  1  fetch request, held until IfDone
IfAddr  in  AW  fetch address, stable while IfReq
IfData  out  DW  fetched instruction, valid when IfDone
IfDone  out  1  one-cycle fetch completion pulse
DReq  in  1  data request (lw/sw), held until DDone
DWe  in  1  1=store, 0=load, stable while DReq
DAddr  in  AW  data address, stable while DReq
DWdata  in  DW  store data, stable while DReq
DRdata  out  DW  load data, valid when DDone after a load
DDone  out  1  one-cycle data completion pulse
MemEn  out  1  memory access active
MemWe  out  1  memory write strobe
MemAddr  out  AW  memory address
MemWdata  out  DW  memory write data
MemRdata  in  DW  memory read data, valid in last access cycle
Stall  out  1  pipeline stall: (IfReq & ~IfDone) | (DReq & ~DDone), combinational

Behaviour:
- Reset (Clrn=0, async): state IDLE, cycle counter 0, streak counter 0. Outputs IfData, DRdata, MemAddr, MemWdata = 0; IfDone, DDone, MemEn, MemWe = 0. A reset mid-access aborts it with no Done pulse; requesters re-issue.
- FSM states: IDLE, BUSY_I, BUSY_D. All Mem* outputs and Done flags are registered.
- Effective requests: effI = IfReq & ~IfDone; effD = DReq & ~DDone. This masking prevents re-granting a request in its own Done cycle.
- IDLE arbitration, decided each cycle and acting at the next edge:
  - effD & effI & streak<STARVE_MAX -> BUSY_D.
  - effD & effI & streak==STARVE_MAX -> BUSY_I.
  - effD only -> BUSY_D.
  - effI only -> BUSY_I.
  - neither -> stay IDLE.
- Streak counter:
  - On a data grant with IfReq high: streak+1, saturating at STARVE_MAX.
  - On a data grant with IfReq low: streak cleared to 0.
  - On a fetch grant: streak cleared to 0.
- Grant edge:
  - MemEn=1, counter=0.
  - MemAddr=IfAddr or DAddr.
  - MemWe=DWe for data, 0 for fetch.
  - MemWdata=DWdata for a store; otherwise it holds its previous value.
- BUSY_x: Mem* outputs are held constant. The counter increments each cycle. On the edge ending the cycle where counter==LAT-1:
  - MemEn and MemWe go to 0; state returns to IDLE.
  - The matching Done is set for exactly one cycle.
  - For a fetch, IfData<=MemRdata. For a load, DRdata<=MemRdata. A store leaves DRdata unchanged.
- Latency: request first seen in IDLE at cycle 0; MemEn high cycles 1..LAT; Done in cycle LAT+1. The Done cycle is an IDLE cycle, so a pending other requester is granted in that same cycle, giving back-to-back service.
- IfData and DRdata hold their values until overwritten by the next access of the same kind.
- MemAddr is not cleared in IDLE; it keeps the last address.
- Request inputs are ignored while BUSY; a request arriving mid-access waits.
- A requester dropping Req before Done is illegal; the behaviour in that case is the access completing regardless, with its Done pulse still issued.

Test Plan:
1. LAT=2, IfReq=1, IfAddr=0x00000010 at cycle 0; memory returns 0x20080005 -> MemEn=1, MemAddr=0x10, MemWe=0 in cycles 1-2; IfDone=1 and IfData=0x20080005 in cycle 3; Stall=1 in cycles 0-2 and 0 in cycle 3.
2. IfReq (IfAddr=0x14) and DReq load (DAddr=0x40) together at cycle 0 -> data granted first, DDone cycle 3; fetch granted in cycle 3, MemAddr=0x14 cycles 4-5, IfDone cycle 6.
3. Store DWe=1, DAddr=0x80, DWdata=0xDEADBEEF, DRdata previously 0x12345678 -> MemWe=1 and MemWdata=0xDEADBEEF in cycles 1-2; DDone cycle 3; DRdata stays 0x12345678.
4. STARVE_MAX=4, IfReq held, DReq re-asserted with a new DAddr on every Done -> exactly 4 data grants, then a fetch grant; the streak resets and data wins again afterwards.
5. Clrn pulsed low in cycle 2 of a load -> MemEn, MemWe, DDone, DRdata go to 0 immediately with no DDone ever; after release, the re-issued load completes with DDone at cycle 3 relative to re-issue.
6. LAT=1 build, single fetch -> MemEn high in cycle 1 only; IfDone in cycle 2; a following data request queued in cycle 2 is granted in cycle 2 with DDone in cycle 4.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Shares one single-ported unified memory between instruction fetch
//           and data (lw/sw) accesses. Data wins over fetch, but fetch is
//           forced through after STARVE_MAX consecutive data grants. Each access
//           holds the port for LAT cycles and ends with a one-cycle Done pulse.
// Revision: 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          Clk,
  input  logic          Clrn,
  input  logic          IfReq,
  input  logic [AW-1:0] IfAddr,
  output logic [DW-1:0] IfData,
  output logic          IfDone,
  input  logic          DReq,
  input  logic          DWe,
  input  logic [AW-1:0] DAddr,
  input  logic [DW-1:0] DWdata,
  output logic [DW-1:0] DRdata,
  output logic          DDone,
  output logic          MemEn,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWdata,
  input  logic [DW-1:0] MemRdata,
  output logic          Stall
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(LAT - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] streak;

  logic eff_i;
  logic eff_d;
  logic grant_d;
  logic grant_i;
  logic last_cycle;

  // A request is masked in its own Done cycle so it cannot be granted twice.
  assign eff_i = IfReq & ~IfDone;
  assign eff_d = DReq & ~DDone;
  assign Stall = eff_i | eff_d;

  // Data wins unless fetch has been passed over STARVE_MAX times in a row.
  assign grant_d    = (state == S_IDLE) & eff_d & (~eff_i | (streak < STREAK_MAX));
  assign grant_i    = (state == S_IDLE) & eff_i & ~grant_d;
  assign last_cycle = ((state == S_BUSY_I) || (state == S_BUSY_D)) && (cnt == CNT_LAST);

  // Sequencer state, access cycle counter and fetch-starvation streak.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state  <= S_IDLE;
      cnt    <= '0;
      streak <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_d) begin
            state <= S_BUSY_D;
            cnt   <= '0;
            if (!IfReq)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + SW'(1);
          end else if (grant_i) begin
            state  <= S_BUSY_I;
            cnt    <= '0;
            streak <= '0;
          end
        end
        S_BUSY_I, S_BUSY_D: begin
          if (last_cycle)
            state <= S_IDLE;
          else
            cnt <= cnt + CW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory port: loaded on a grant, held during the access, strobes dropped at the end.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      MemEn    <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWdata <= '0;
    end else if (grant_d) begin
      MemEn   <= 1'b1;
      MemWe   <= DWe;
      MemAddr <= DAddr;
      if (DWe)
        MemWdata <= DWdata;
    end else if (grant_i) begin
      MemEn   <= 1'b1;
      MemWe   <= 1'b0;
      MemAddr <= IfAddr;
    end else if (last_cycle) begin
      MemEn <= 1'b0;
      MemWe <= 1'b0;
    end
  end

  // Completion: one-cycle Done pulse and read-data capture for the finishing access.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      IfDone <= 1'b0;
      DDone  <= 1'b0;
      IfData <= '0;
      DRdata <= '0;
    end else begin
      IfDone <= 1'b0;
      DDone  <= 1'b0;
      if (last_cycle) begin
        if (state == S_BUSY_I) begin
          IfDone <= 1'b1;
          IfData <= MemRdata;
        end else begin
          DDone <= 1'b1;
          if (!MemWe)
            DRdata <= MemRdata;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Self-checking bench for mem_port_arbiter: directed scenarios plus
//           randomized requesters checked against a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int SM  = 4;

  logic          Clk = 1'b0;
  logic          Clrn;
  logic          IfReq;
  logic [AW-1:0] IfAddr;
  logic [DW-1:0] IfData;
  logic          IfDone;
  logic          DReq;
  logic          DWe;
  logic [AW-1:0] DAddr;
  logic [DW-1:0] DWdata;
  logic [DW-1:0] DRdata;
  logic          DDone;
  logic          MemEn;
  logic          MemWe;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWdata;
  logic [DW-1:0] MemRdata;
  logic          Stall;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .STARVE_MAX(SM)) dut (
    .Clk(Clk), .Clrn(Clrn),
    .IfReq(IfReq), .IfAddr(IfAddr), .IfData(IfData), .IfDone(IfDone),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata),
    .DRdata(DRdata), .DDone(DDone),
    .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemRdata(MemRdata), .Stall(Stall)
  );

  always #5 Clk = ~Clk;

  // Memory contents: a couple of fixed words, everything else a hash of the address.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h10) return 32'h20080005;
    if (a == 32'h44) return 32'h12345678;
    return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  assign MemRdata = mem_val(MemAddr);

  // ---------------- reference model (transaction level) ----------------
  int          m_kind;      // 0 none, 1 fetch in flight, 2 data in flight
  int          m_left;      // port cycles remaining for the access in flight
  int          m_streak;
  logic        m_en, m_we, m_ifdone, m_ddone;
  logic [31:0] m_addr, m_wdata, m_ifdata, m_drdata;
  logic        m_ei, m_ed;

  always @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      m_kind = 0; m_left = 0; m_streak = 0;
      m_en = 0; m_we = 0; m_ifdone = 0; m_ddone = 0;
      m_addr = 0; m_wdata = 0; m_ifdata = 0; m_drdata = 0;
    end else begin
      m_ei = IfReq & ~m_ifdone;
      m_ed = DReq & ~m_ddone;
      m_ifdone = 0;
      m_ddone  = 0;
      if (m_kind == 0) begin
        if (m_ed && (!m_ei || m_streak < SM)) begin
          m_kind = 2; m_left = LAT; m_en = 1; m_we = DWe; m_addr = DAddr;
          if (DWe) m_wdata = DWdata;
          m_streak = IfReq ? ((m_streak + 1 > SM) ? SM : m_streak + 1) : 0;
        end else if (m_ei) begin
          m_kind = 1; m_left = LAT; m_en = 1; m_we = 0; m_addr = IfAddr;
          m_streak = 0;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_kind == 1) begin
            m_ifdone = 1; m_ifdata = mem_val(m_addr);
          end else begin
            m_ddone = 1;
            if (!m_we) m_drdata = mem_val(m_addr);
          end
          m_kind = 0; m_en = 0; m_we = 0;
        end
      end
    end
  end

  logic [132:0] dut_vec, mdl_vec;
  assign dut_vec = {MemEn, MemWe, MemAddr, MemWdata, IfDone, DDone, IfData, DRdata, Stall};
  assign mdl_vec = {m_en, m_we, m_addr, m_wdata, m_ifdone, m_ddone, m_ifdata, m_drdata,
                    (IfReq & ~m_ifdone) | (DReq & ~m_ddone)};

  // ---------------- scenarios ----------------
  task automatic test_reset;
    Clrn = 0; IfReq = 0; IfAddr = 0; DReq = 0; DWe = 0; DAddr = 0; DWdata = 0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks++; if (MemEn !== 1'b0)  begin errors++; $display("FAIL reset_memen got %b want 0", MemEn); end
    checks++; if (MemWe !== 1'b0)  begin errors++; $display("FAIL reset_memwe got %b want 0", MemWe); end
    checks++; if (IfDone !== 1'b0 || DDone !== 1'b0) begin errors++; $display("FAIL reset_done got %b%b want 00", IfDone, DDone); end
    checks++; if (MemAddr !== 32'h0 || MemWdata !== 32'h0) begin errors++; $display("FAIL reset_port got %h/%h want 0/0", MemAddr, MemWdata); end
    checks++; if (IfData !== 32'h0 || DRdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h want 0/0", IfData, DRdata); end
    checks++; if (Stall !== 1'b0)  begin errors++; $display("FAIL reset_stall got %b want 0", Stall); end
    Clrn = 1;
    repeat (2) @(posedge Clk);
  endtask

  task automatic test_single_fetch;
    @(posedge Clk); #1 IfReq = 1; IfAddr = 32'h10;
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) @(posedge Clk);
      @(negedge Clk);
      checks++; if (MemEn !== (c == 1 || c == 2)) begin errors++; $display("FAIL fetch_memen c%0d got %b", c, MemEn); end
      if (c == 1 || c == 2) begin
        checks++; if (MemAddr !== 32'h10 || MemWe !== 1'b0) begin errors++; $display("FAIL fetch_port c%0d got %h we %b want 10 we 0", c, MemAddr, MemWe); end
      end
      checks++; if (IfDone !== (c == 3)) begin errors++; $display("FAIL fetch_done c%0d got %b", c, IfDone); end
      checks++; if (Stall !== (c < 3)) begin errors++; $display("FAIL fetch_stall c%0d got %b", c, Stall); end
    end
    checks++; if (IfData !== 32'h20080005) begin errors++; $display("FAIL fetch_data got %h want 20080005", IfData); end
    @(posedge Clk); #1 IfReq = 0;
  endtask

  task automatic test_contention;
    @(posedge Clk); #1 IfReq = 1; IfAddr = 32'h14; DReq = 1; DWe = 0; DAddr = 32'h40;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) begin @(posedge Clk); #1 if (c == 4) DReq = 0; end
      @(negedge Clk);
      checks++; if (MemEn !== (c == 1 || c == 2 || c == 4 || c == 5)) begin errors++; $display("FAIL cont_memen c%0d got %b", c, MemEn); end
      if (c == 1 || c == 2 || c == 4 || c == 5) begin
        checks++; if (MemAddr !== ((c < 3) ? 32'h40 : 32'h14)) begin errors++; $display("FAIL cont_addr c%0d got %h", c, MemAddr); end
      end
      checks++; if (DDone !== (c == 3) || IfDone !== (c == 6)) begin errors++; $display("FAIL cont_done c%0d got d%b i%b", c, DDone, IfDone); end
      if (c == 3) begin
        checks++; if (DRdata !== mem_val(32'h40)) begin errors++; $display("FAIL cont_drdata got %h want %h", DRdata, mem_val(32'h40)); end
      end
    end
    @(posedge Clk); #1 IfReq = 0;
  endtask

  task automatic test_store;
    bit seen;
    // preload DRdata with a known word
    @(posedge Clk); #1 DReq = 1; DWe = 0; DAddr = 32'h44;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge Clk);
      if (DDone === 1'b1) seen = 1;
      else @(posedge Clk);
    end
    checks++; if (!seen || DRdata !== 32'h12345678) begin errors++; $display("FAIL preload_load done %b got %h want 12345678", seen, DRdata); end
    @(posedge Clk); #1 DWe = 1; DAddr = 32'h80; DWdata = 32'hDEADBEEF;
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) @(posedge Clk);
      @(negedge Clk);
      checks++; if (MemWe !== (c == 1 || c == 2)) begin errors++; $display("FAIL store_we c%0d got %b", c, MemWe); end
      if (c == 1 || c == 2) begin
        checks++; if (MemWdata !== 32'hDEADBEEF || MemAddr !== 32'h80) begin errors++; $display("FAIL store_port c%0d got %h@%h", c, MemWdata, MemAddr); end
      end
      checks++; if (DDone !== (c == 3)) begin errors++; $display("FAIL store_done c%0d got %b", c, DDone); end
    end
    checks++; if (DRdata !== 32'h12345678) begin errors++; $display("FAIL store_drdata got %h want 12345678", DRdata); end
    @(posedge Clk); #1 DReq = 0; DWe = 0;
  endtask

  task automatic test_reset_mid_access;
    @(posedge Clk); #1 DReq = 1; DWe = 0; DAddr = 32'h48;
    @(posedge Clk); @(posedge Clk); #1 Clrn = 0;
    #1;
    checks++; if (MemEn !== 1'b0 || MemWe !== 1'b0 || DDone !== 1'b0) begin errors++; $display("FAIL midrst_ctl got en%b we%b dd%b want 000", MemEn, MemWe, DDone); end
    checks++; if (DRdata !== 32'h0) begin errors++; $display("FAIL midrst_drdata got %h want 0", DRdata); end
    @(negedge Clk); Clrn = 1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge Clk);
      checks++; if (MemEn !== (k < 3) || DDone !== (k == 3)) begin errors++; $display("FAIL midrst_reissue k%0d got en%b dd%b", k, MemEn, DDone); end
      checks++; if (dut_vec !== mdl_vec) begin errors++; $display("FAIL midrst_model k%0d got %h want %h", k, dut_vec, mdl_vec); end
    end
    checks++; if (DRdata !== mem_val(32'h48)) begin errors++; $display("FAIL midrst_data got %h want %h", DRdata, mem_val(32'h48)); end
    @(posedge Clk); #1 DReq = 0;
    @(posedge Clk);
  endtask

  task automatic test_random(input int ncyc);
    bit if_done_seen, d_done_seen;
    if_done_seen = 0; d_done_seen = 0;
    for (int n = 0; n < ncyc; n++) begin
      @(posedge Clk); #1;
      if (IfReq) begin
        if (if_done_seen) begin
          if_done_seen = 0;
          if ($urandom_range(0, 1) == 1) IfAddr = $urandom & 32'hFFFC;
          else IfReq = 0;
        end else if (IfDone) if_done_seen = 1;
      end else if ($urandom_range(0, 2) == 0) begin
        IfReq = 1; IfAddr = $urandom & 32'hFFFC;
      end
      if (DReq) begin
        if (d_done_seen) begin
          d_done_seen = 0;
          if ($urandom_range(0, 1) == 1) begin
            DWe = $urandom_range(0, 1) == 1; DAddr = $urandom & 32'hFFFC; DWdata = $urandom;
          end else DReq = 0;
        end else if (DDone) d_done_seen = 1;
      end else if ($urandom_range(0, 2) == 0) begin
        DReq = 1; DWe = $urandom_range(0, 1) == 1; DAddr = $urandom & 32'hFFFC; DWdata = $urandom;
      end
      @(negedge Clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++;
        $display("FAIL random_cycle %0d got %h want %h", n, dut_vec, mdl_vec);
      end
    end
    @(posedge Clk); #1 IfReq = 0; DReq = 0;
    repeat (LAT + 3) @(posedge Clk);
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_store();
    test_reset_mid_access();
    test_random(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
